// File: rtl/vjtag_bridge_pkg.sv
// Shared definitions for the virtual-JTAG memory bridge.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: virtual IR codes, bridge FSM states, STATUS DR bit positions
// and STATUS DR width.
// Optional feature macro: VJTAG_BRIDGE_WRCNT_EN (adds a 16-bit write counter
// to the STATUS DR, widening it from 8 to 24 bits).
package vjtag_bridge_pkg;

  // Virtual IR codes; 110/111 are unassigned and decode as BYPASS.
  localparam logic [2:0] IR_BYPASS = 3'b000;
  localparam logic [2:0] IR_ADDR   = 3'b001;
  localparam logic [2:0] IR_WRITE  = 3'b010;
  localparam logic [2:0] IR_READ   = 3'b011;
  localparam logic [2:0] IR_STATUS = 3'b100;
  localparam logic [2:0] IR_CTRL   = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_WAIT = 2'd3
  } fsm_state_t;

  // Bit positions inside the low status byte.
  localparam int STAT_FSM_BUSY = 0;
  localparam int STAT_ACC_BUSY = 1;
  localparam int STAT_ACC_DONE = 2;
  localparam int STAT_OVERRUN  = 3;

  localparam int STATUS8_W = 8;

`ifdef VJTAG_BRIDGE_WRCNT_EN
  localparam int WRCNT_W  = 16;
  localparam int STATUS_W = STATUS8_W + WRCNT_W;
`else
  localparam int STATUS_W = STATUS8_W;
`endif

  // Assemble the low status byte; upper nibble is reserved and reads 0.
  function automatic logic [STATUS8_W-1:0] pack_status(
    input logic overrun,
    input logic acc_done,
    input logic acc_busy,
    input logic fsm_busy
  );
    logic [STATUS8_W-1:0] s;
    s                = '0;
    s[STAT_OVERRUN]  = overrun;
    s[STAT_ACC_DONE] = acc_done;
    s[STAT_ACC_BUSY] = acc_busy;
    s[STAT_FSM_BUSY] = fsm_busy;
    return s;
  endfunction

endpackage

// File: rtl/vjtag_dr_shifter.sv
// One JTAG data register: parallel capture, LSB-first serial shift, tdo bit.
// Latency: capture/shift take effect on the tck edge where the strobe is high.
// Backpressure: none; strobes are obeyed unconditionally, capture wins over shift.
//
// Ports:
//   tck, rst_n      clock and synchronous active-low reset
//   capture, shift  gated cdr/sdr strobes for this register
//   tdi             serial input, enters at the MSB
//   cap_val         value loaded on capture
//   sr              register contents (update value after a full scan)
//   tdo             current LSB, straight from the register
module vjtag_dr_shifter #(
  parameter int W = 8
) (
  input  logic         tck,
  input  logic         rst_n,
  input  logic         capture,
  input  logic         shift,
  input  logic         tdi,
  input  logic [W-1:0] cap_val,
  output logic [W-1:0] sr,
  output logic         tdo
);

  logic [W-1:0] next_sr;

  generate
    if (W == 1) begin : g_w1
      assign next_sr = tdi;
    end else begin : g_wn
      assign next_sr = {tdi, sr[W-1:1]};
    end
  endgenerate

  always_ff @(posedge tck) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (capture) begin
      sr <= cap_val;
    end else if (shift) begin
      sr <= next_sr;
    end
  end

  // tdo comes only from a flop, so tdi never reaches tdo combinationally.
  assign tdo = sr[0];

endmodule

// File: rtl/vjtag_mem_bridge.sv
// vJtag consumer: virtual-IR decode, DR scans, single-beat memory and accelerator control.
// Latency: memory strobe one tck after udr; read data lands in the read buffer 2 tck after mem_re rises.
// Backpressure: none; an update that needs the busy FSM is dropped and sets sticky overrun.
//
// Ports:
//   tck, rst_n                    clock, synchronous active-low reset
//   tdi, tdo                      serial data from/to vJtag
//   ir_in, ir_out                 current virtual IR, captured-IR status {overrun, acc_done, acc_busy}
//   virtual_state_cdr/sdr/udr/uir vJtag TAP state strobes
//   mem_addr, mem_wdata           memory address and write data
//   mem_we, mem_re                single-tck write/read strobes
//   mem_rdata                     read data, valid one tck after mem_re
//   acc_start                     single-tck downscaler start pulse
//   acc_busy, acc_done            downscaler status levels
// Optional feature macro: VJTAG_BRIDGE_WRCNT_EN (write counter in STATUS DR).
module vjtag_mem_bridge
  import vjtag_bridge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int IR_W   = 3
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic              tdi,
  output logic              tdo,
  input  logic [IR_W-1:0]   ir_in,
  output logic [IR_W-1:0]   ir_out,
  input  logic              virtual_state_cdr,
  input  logic              virtual_state_sdr,
  input  logic              virtual_state_udr,
  input  logic              virtual_state_uir,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              acc_start,
  input  logic              acc_busy,
  input  logic              acc_done
);

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic sel_addr, sel_write, sel_read, sel_data, sel_status, sel_ctrl, sel_bypass;

  assign sel_addr   = (ir_in == IR_ADDR);
  assign sel_write  = (ir_in == IR_WRITE);
  assign sel_read   = (ir_in == IR_READ);
  assign sel_status = (ir_in == IR_STATUS);
  assign sel_ctrl   = (ir_in == IR_CTRL);
  // WRITE and READ share one DATA_W register; only the capture value differs.
  assign sel_data   = sel_write | sel_read;
  // Anything not claimed above (000, 110, 111) is a 1-bit bypass.
  assign sel_bypass = ~(sel_addr | sel_data | sel_status | sel_ctrl);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  fsm_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;
  logic [DATA_W-1:0] rd_buf;
  logic              overrun;
  logic              fsm_free;
  logic              upd_rd, upd_wr, need_fsm;

  assign ptr_inc  = ptr + ADDR_W'(1);
  assign fsm_free = (state_q == ST_IDLE);
  assign upd_rd   = virtual_state_udr & (sel_addr | sel_read);
  assign upd_wr   = virtual_state_udr & sel_write;
  assign need_fsm = sel_addr | sel_write | sel_read;

  // ---------------------------------------------------------------------------
  // DR capture values
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]    rd_cap;
  logic [DATA_W-1:0]    data_cap;
  logic [STATUS8_W-1:0] status8;
  logic [STATUS_W-1:0]  status_cap;

  // A capture landing on the same edge the prefetch completes must see the new
  // word, so forward mem_rdata past the read buffer during RD_WAIT.
  assign rd_cap   = (state_q == ST_RD_WAIT) ? mem_rdata : rd_buf;
  assign data_cap = sel_read ? rd_cap : '0;
  assign status8  = pack_status(overrun, acc_done, acc_busy, ~fsm_free);

`ifdef VJTAG_BRIDGE_WRCNT_EN
  logic [WRCNT_W-1:0] wr_count;

  // Counts issued write strobes; a STATUS update reads-and-clears it.
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (virtual_state_udr && sel_status) begin
      wr_count <= '0;
    end else if (mem_we) begin
      wr_count <= wr_count + WRCNT_W'(1);
    end
  end

  assign status_cap = {wr_count, status8};
`else
  assign status_cap = status8;
`endif

  // ---------------------------------------------------------------------------
  // Data registers
  // ---------------------------------------------------------------------------
  logic [0:0]          byp_sr, ctrl_sr;
  logic [ADDR_W-1:0]   addr_sr;
  logic [DATA_W-1:0]   data_sr;
  logic [STATUS_W-1:0] status_sr;
  logic                byp_tdo, addr_tdo, data_tdo, status_tdo, ctrl_tdo;

  vjtag_dr_shifter #(.W(1)) u_dr_bypass (
    .tck     (tck),
    .rst_n   (rst_n),
    .capture (virtual_state_cdr & sel_bypass),
    .shift   (virtual_state_sdr & sel_bypass),
    .tdi     (tdi),
    .cap_val (1'b0),
    .sr      (byp_sr),
    .tdo     (byp_tdo)
  );

  vjtag_dr_shifter #(.W(ADDR_W)) u_dr_addr (
    .tck     (tck),
    .rst_n   (rst_n),
    .capture (virtual_state_cdr & sel_addr),
    .shift   (virtual_state_sdr & sel_addr),
    .tdi     (tdi),
    .cap_val (ptr),
    .sr      (addr_sr),
    .tdo     (addr_tdo)
  );

  vjtag_dr_shifter #(.W(DATA_W)) u_dr_data (
    .tck     (tck),
    .rst_n   (rst_n),
    .capture (virtual_state_cdr & sel_data),
    .shift   (virtual_state_sdr & sel_data),
    .tdi     (tdi),
    .cap_val (data_cap),
    .sr      (data_sr),
    .tdo     (data_tdo)
  );

  vjtag_dr_shifter #(.W(STATUS_W)) u_dr_status (
    .tck     (tck),
    .rst_n   (rst_n),
    .capture (virtual_state_cdr & sel_status),
    .shift   (virtual_state_sdr & sel_status),
    .tdi     (tdi),
    .cap_val (status_cap),
    .sr      (status_sr),
    .tdo     (status_tdo)
  );

  vjtag_dr_shifter #(.W(1)) u_dr_ctrl (
    .tck     (tck),
    .rst_n   (rst_n),
    .capture (virtual_state_cdr & sel_ctrl),
    .shift   (virtual_state_sdr & sel_ctrl),
    .tdi     (tdi),
    .cap_val (1'b0),
    .sr      (ctrl_sr),
    .tdo     (ctrl_tdo)
  );

  // Shifted-in contents of BYPASS and STATUS carry no meaning.
  logic unused_sr;
  assign unused_sr = ^{byp_sr, status_sr};

  always_comb begin
    tdo = byp_tdo;
    if (sel_addr) begin
      tdo = addr_tdo;
    end else if (sel_data) begin
      tdo = data_tdo;
    end else if (sel_status) begin
      tdo = status_tdo;
    end else if (sel_ctrl) begin
      tdo = ctrl_tdo;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory access FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (upd_rd) begin
          state_d = ST_RD_REQ;
        end else if (upd_wr) begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        mem_we  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_REQ: begin
        mem_re  = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Update handling: pointer, memory address/data, accelerator pulse, overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge tck) begin
    if (!rst_n) begin
      ptr       <= '0;
      rd_buf    <= '0;
      overrun   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      acc_start <= 1'b0;
      ir_out    <= '0;
    end else begin
      acc_start <= 1'b0;

      if (state_q == ST_RD_WAIT) begin
        rd_buf <= mem_rdata;
      end

      if (virtual_state_uir) begin
        ir_out <= {overrun, acc_done, acc_busy};
      end

      if (virtual_state_udr) begin
        if (need_fsm && !fsm_free) begin
          // Memory update while an access is still in flight: drop it whole.
          overrun <= 1'b1;
        end else if (sel_addr) begin
          ptr      <= addr_sr;
          mem_addr <= addr_sr;
        end else if (sel_write) begin
          mem_wdata <= data_sr;
          mem_addr  <= ptr;
          ptr       <= ptr_inc;
        end else if (sel_read) begin
          // Advance past the word just read out and prefetch the next one.
          ptr      <= ptr_inc;
          mem_addr <= ptr_inc;
        end else if (sel_ctrl && ctrl_sr[0]) begin
          if (acc_busy) begin
            overrun <= 1'b1;
          end else begin
            acc_start <= 1'b1;
          end
        end else if (sel_status) begin
          overrun <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vjtag_mem_bridge.sv
`timescale 1ns/1ps
module tb_vjtag_mem_bridge;

  localparam logic [2:0] I_BYPASS = 3'b000;
  localparam logic [2:0] I_ADDR   = 3'b001;
  localparam logic [2:0] I_WRITE  = 3'b010;
  localparam logic [2:0] I_READ   = 3'b011;
  localparam logic [2:0] I_STATUS = 3'b100;
  localparam logic [2:0] I_CTRL   = 3'b101;
`ifdef VJTAG_BRIDGE_WRCNT_EN
  localparam int ST_W = 24;
`else
  localparam int ST_W = 8;
`endif

  logic        tck = 1'b0;
  logic        rst_n = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [2:0]  ir_in = 3'b000;
  logic [2:0]  ir_out;
  logic        cdr = 1'b0, sdr = 1'b0, udr = 1'b0, uir = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_we, mem_re, acc_start;
  logic        acc_busy = 1'b0, acc_done = 1'b0;

  always #5 tck = ~tck;

  vjtag_mem_bridge #(.DATA_W(8), .ADDR_W(16), .IR_W(3)) dut (
    .tck               (tck),
    .rst_n             (rst_n),
    .tdi               (tdi),
    .tdo               (tdo),
    .ir_in             (ir_in),
    .ir_out            (ir_out),
    .virtual_state_cdr (cdr),
    .virtual_state_sdr (sdr),
    .virtual_state_udr (udr),
    .virtual_state_uir (uir),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_we            (mem_we),
    .mem_re            (mem_re),
    .mem_rdata         (mem_rdata),
    .acc_start         (acc_start),
    .acc_busy          (acc_busy),
    .acc_done          (acc_done)
  );

  // Image memory attached to the bridge (read data one tck after mem_re).
  logic [7:0] ram [0:65535];
  always @(posedge tck) begin
    if (mem_re) mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Reference model: host-visible state of the bridge.
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] m_ptr = 16'h0000;
  logic [7:0]  m_rdbuf = 8'h00;
  logic        m_ovr = 1'b0;
  logic [15:0] m_wrcnt = 16'h0000;

  typedef struct { bit we; logic [15:0] addr; logic [7:0] data; } mem_txn_t;
  typedef struct { logic [31:0] val; int width; } dr_exp_t;
  mem_txn_t exp_mem[$];
  dr_exp_t  exp_dr[$];
  bit       exp_acc[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  mem_txn_t mt;
  always @(negedge tck) begin
    if (mem_we || mem_re) begin
      if (exp_mem.size() == 0) begin
        checks++; failures++;
        $display("FAIL mem_unexpected: we=%b re=%b addr=%h wdata=%h, none expected", mem_we, mem_re, mem_addr, mem_wdata);
      end else begin
        mt = exp_mem.pop_front();
        check("mem_kind", 32'({mem_we, mem_re}), mt.we ? 32'd2 : 32'd1);
        check("mem_addr", 32'(mem_addr), 32'(mt.addr));
        if (mt.we) check("mem_wdata", 32'(mem_wdata), 32'(mt.data));
      end
    end
  end

  logic [31:0] dr_bits = 32'd0;
  int          dr_cnt = 0;
  dr_exp_t     de;
  always @(negedge tck) begin
    if (sdr) begin
      if (dr_cnt < 32) dr_bits[dr_cnt[4:0]] = tdo;
      dr_cnt++;
    end else if (dr_cnt > 0) begin
      if (exp_dr.size() == 0) begin
        checks++; failures++;
        $display("FAIL dr_unexpected: got %h, no scan expected", dr_bits);
      end else begin
        de = exp_dr.pop_front();
        check("dr_len", 32'(dr_cnt), 32'(de.width));
        check("dr_capture", dr_bits, de.val);
      end
      dr_cnt = 0;
      dr_bits = 32'd0;
    end
  end

  bit acc_prev = 1'b0;
  always @(negedge tck) begin
    if (acc_start === 1'b1) begin
      checks++;
      if (acc_prev) begin
        failures++;
        $display("FAIL acc_width: acc_start high for more than one tck, required 1");
      end else if (exp_acc.size() == 0) begin
        failures++;
        $display("FAIL acc_unexpected: acc_start=1, required 0");
      end else begin
        void'(exp_acc.pop_front());
      end
    end
    acc_prev = (acc_start === 1'b1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic dr_scan(input logic [2:0] ir, input int width, input logic [31:0] din,
                         input logic [31:0] exp_cap, input bit dbl_udr);
    dr_exp_t e;
    e.val = exp_cap; e.width = width;
    exp_dr.push_back(e);
    @(posedge tck); #1 ir_in = ir;
    @(posedge tck); #1 cdr = 1'b1;
    @(posedge tck); #1 cdr = 1'b0; sdr = 1'b1;
    for (int i = 0; i < width; i++) begin
      tdi = din[i];
      @(posedge tck); #1;
    end
    sdr = 1'b0; udr = 1'b1;
    @(posedge tck); #1;
    if (dbl_udr) begin
      @(posedge tck); #1;
    end
    udr = 1'b0;
    repeat (4) @(posedge tck);
    #1;
  endtask

  task automatic op_addr(input logic [15:0] a);
    mem_txn_t t;
    logic [31:0] cap;
    cap = 32'(m_ptr);
    m_ptr = a; m_rdbuf = ref_mem[a];
    t.we = 1'b0; t.addr = a; t.data = 8'h00;
    exp_mem.push_back(t);
    dr_scan(I_ADDR, 16, 32'(a), cap, 1'b0);
  endtask

  task automatic op_write(input logic [7:0] d, input bit dbl);
    mem_txn_t t;
    t.we = 1'b1; t.addr = m_ptr; t.data = d;
    exp_mem.push_back(t);
    ref_mem[m_ptr] = d;
    m_ptr = m_ptr + 16'd1;
    m_wrcnt = m_wrcnt + 16'd1;
    if (dbl) m_ovr = 1'b1;
    dr_scan(I_WRITE, 8, 32'(d), 32'd0, dbl);
  endtask

  task automatic op_read();
    mem_txn_t t;
    logic [31:0] cap;
    cap = 32'(m_rdbuf);
    m_ptr = m_ptr + 16'd1;
    m_rdbuf = ref_mem[m_ptr];
    t.we = 1'b0; t.addr = m_ptr; t.data = 8'h00;
    exp_mem.push_back(t);
    dr_scan(I_READ, 8, $urandom, cap, 1'b0);
  endtask

  task automatic op_status();
    logic [31:0] cap;
`ifdef VJTAG_BRIDGE_WRCNT_EN
    cap = {8'd0, m_wrcnt, 4'b0000, m_ovr, acc_done, acc_busy, 1'b0};
`else
    cap = {24'd0, 4'b0000, m_ovr, acc_done, acc_busy, 1'b0};
`endif
    m_ovr = 1'b0;
    m_wrcnt = 16'h0000;
    dr_scan(I_STATUS, ST_W, $urandom, cap, 1'b0);
  endtask

  task automatic op_ctrl(input bit v);
    if (v) begin
      if (acc_busy) m_ovr = 1'b1;
      else exp_acc.push_back(1'b1);
    end
    dr_scan(I_CTRL, 1, 32'(v), 32'd0, 1'b0);
  endtask

  task automatic pulse_uir(input string name);
    logic [2:0] exp;
    exp = {m_ovr, acc_done, acc_busy};
    @(posedge tck); #1 uir = 1'b1;
    @(posedge tck); #1 uir = 1'b0;
    check(name, 32'(ir_out), 32'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tdo"}, 32'(tdo), 32'd0);
    check({tag, "_ir_out"}, 32'(ir_out), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_strobes"}, 32'({mem_we, mem_re, acc_start}), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[16'h0020] = 8'h11; ref_mem[16'h0020] = 8'h11;
    ram[16'h0021] = 8'h22; ref_mem[16'h0021] = 8'h22;

    repeat (3) @(posedge tck);
    #1 rst_n = 1'b1;
    check_reset_outputs("rst");

    // Address load and sequential writes; final ADDR capture shows pointer 0x0012.
    op_addr(16'h0010);
    op_write(8'hA5, 1'b0);
    op_write(8'h3C, 1'b0);
    op_addr(16'h0020);
    // Prefetched reads stream 0x11 then 0x22.
    op_read();
    op_read();
    // Pointer wrap.
    op_addr(16'hFFFF);
    op_write(8'h77, 1'b0);
    op_write(8'h88, 1'b0);
    op_addr(16'h0040);

    // Accelerator start, then a refused start while busy.
    acc_busy = 1'b0;
    op_ctrl(1'b1);
    op_ctrl(1'b0);
    acc_busy = 1'b1; acc_done = 1'b1;
    op_ctrl(1'b1);
    pulse_uir("uir_overrun");
    op_status();
    op_status();
    acc_busy = 1'b0; acc_done = 1'b0;

    // Back-to-back updates: only the first write issues.
    op_write(8'h5A, 1'b1);
    op_status();

    // Reset in the middle of a WRITE shift.
    begin
      dr_exp_t e;
      e.val = 32'd0; e.width = 4;
      exp_dr.push_back(e);
      @(posedge tck); #1 ir_in = I_WRITE;
      @(posedge tck); #1 cdr = 1'b1;
      @(posedge tck); #1 cdr = 1'b0; sdr = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tdi = 1'($urandom);
        @(posedge tck); #1;
      end
      sdr = 1'b0; rst_n = 1'b0;
      @(posedge tck); #1 rst_n = 1'b1;
      check_reset_outputs("midscan_rst");
      m_ptr = 16'h0000; m_rdbuf = 8'h00; m_ovr = 1'b0; m_wrcnt = 16'h0000;
      repeat (4) @(posedge tck);
      #1;
    end
    op_status();
    op_addr(16'h0100);

    // Three writes, then STATUS (write count visible when enabled).
    op_write(8'h01, 1'b0);
    op_write(8'h02, 1'b0);
    op_write(8'h03, 1'b0);
    op_status();

    // Randomised traffic against the model.
    for (int n = 0; n < 80; n++) begin
      acc_busy = 1'($urandom);
      acc_done = 1'($urandom);
      case ($urandom_range(0, 6))
        0: op_addr(16'($urandom));
        1, 2: op_write(8'($urandom), 1'b0);
        3: op_read();
        4: op_status();
        5: op_ctrl(1'($urandom));
        default: dr_scan(($urandom_range(0, 1) == 0) ? I_BYPASS : 3'(3'b110 + 3'($urandom_range(0, 1))),
                         1, $urandom, 32'd0, 1'b0);
      endcase
      if ((n % 16) == 15) pulse_uir("uir_random");
    end

    repeat (10) @(posedge tck);
    #1;
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("exp_dr_drained", 32'(exp_dr.size()), 32'd0);
    check("exp_acc_drained", 32'(exp_acc.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
